// File: rtl/hook_pkg.sv
// Shared types and constants for the claw hook: state encoding, default geometry
// and the fixed-point scale used by circle_object's unit vector.
package hook_pkg;

    typedef enum logic [1:0] {
        SWING   = 2'd0,
        EXTEND  = 2'd1,
        RETRACT = 2'd2
    } hook_state_t;

    localparam int DEF_PIVOT_X = 320;
    localparam int DEF_PIVOT_Y = 64;
    localparam int DEF_MIN_LEN = 24;
    localparam int DEF_MAX_LEN = 400;

    // dx/dy arrive as a unit vector scaled to 1023; a right shift by 10 undoes it.
    localparam int UNIT_SCALE  = 1023;
    localparam int SCALE_SHIFT = 10;

endpackage

// File: rtl/hook_tip_calc.sv
// Combinational tip position: pivot plus rope_len scaled by the unit vector,
// mirrored in x when the hook points into the left half.
module hook_tip_calc
    import hook_pkg::*;
#(
    parameter int PIVOT_X = DEF_PIVOT_X,
    parameter int PIVOT_Y = DEF_PIVOT_Y
) (
    input  logic [9:0]  rope_len,
    input  logic [9:0]  dx,
    input  logic [9:0]  dy,
    input  logic        left_side,
    output logic [10:0] tip_x,
    output logic [10:0] tip_y
);

    logic [19:0] prod_x;
    logic [19:0] prod_y;
    logic [9:0]  off_x;
    logic [9:0]  off_y;

    assign prod_x = {10'd0, rope_len} * {10'd0, dx};
    assign prod_y = {10'd0, rope_len} * {10'd0, dy};
    assign off_x  = prod_x[SCALE_SHIFT +: 10];
    assign off_y  = prod_y[SCALE_SHIFT +: 10];

    assign tip_x = left_side ? (11'(PIVOT_X) - {1'b0, off_x})
                             : (11'(PIVOT_X) + {1'b0, off_x});
    assign tip_y = 11'(PIVOT_Y) + {1'b0, off_y};

endmodule

// File: rtl/hook_swing_controller.sv
// Claw hook controller: swings the angle at the pivot, shoots and reels the rope,
// and registers the tip coordinates for the sprite and collision logic.
module hook_swing_controller
    import hook_pkg::*;
#(
    parameter int THETA_MIN     = 10,
    parameter int THETA_MAX     = 170,
    parameter int SWING_DIV     = 2,
    parameter int EXTEND_SPEED  = 4,
    parameter int RETRACT_SPEED = 4,
    parameter int MIN_LEN       = DEF_MIN_LEN,
    parameter int MAX_LEN       = DEF_MAX_LEN,
    parameter int PIVOT_X       = DEF_PIVOT_X,
    parameter int PIVOT_Y       = DEF_PIVOT_Y
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        shoot_key,
    input  logic        hook_collision,
    input  logic        border_hit,
    input  logic [1:0]  weight,
    input  logic [9:0]  dx_in,
    input  logic [9:0]  dy_in,
    output logic [6:0]  alpha,
    output logic        left_side,
    output logic [9:0]  rope_len,
    output logic [10:0] hookTipX,
    output logic [10:0] hookTipY,
    output logic [1:0]  hook_state,
    output logic        grabbed,
    output logic        hook_returned
);

    localparam logic [7:0]  TH_MIN    = 8'(THETA_MIN);
    localparam logic [7:0]  TH_MAX    = 8'(THETA_MAX);
    localparam logic [7:0]  DIV_LAST  = 8'(SWING_DIV - 1);
    localparam logic [9:0]  MIN_L     = 10'(MIN_LEN);
    localparam logic [9:0]  MAX_L     = 10'(MAX_LEN);
    localparam logic [9:0]  EXT_S     = 10'(EXTEND_SPEED);
    localparam logic [9:0]  RET_S     = 10'(RETRACT_SPEED);
    localparam logic [10:0] TIP_X_RST = 11'(PIVOT_X);
    localparam logic [10:0] TIP_Y_RST = 11'(PIVOT_Y + ((MIN_LEN * UNIT_SCALE) >>> SCALE_SHIFT));

    hook_state_t state, state_nx;
    logic [7:0]  theta, theta_nx, theta_step;
    logic        swing_up, swing_up_nx;
    logic [7:0]  frame_cnt, frame_cnt_nx;
    logic [9:0]  len_nx;
    logic        grabbed_nx, returned_nx;
    logic        shoot_q, shoot_edge;
    logic [9:0]  shifted, ret_step;
    logic [10:0] tip_x_c, tip_y_c;

    assign shoot_edge = shoot_key & ~shoot_q;
    assign theta_step = swing_up ? (theta + 8'd1) : (theta - 8'd1);
    assign hook_state = state;

    always_comb begin
        if (theta > 8'd90) begin
            left_side = 1'b1;
            alpha     = 7'(8'd180 - theta);
        end else begin
            left_side = 1'b0;
            alpha     = theta[6:0];
        end
    end

    // A grabbed load reels in slower with weight, but never stalls.
    always_comb begin
        shifted = RET_S >> weight;
        if (!grabbed)
            ret_step = RET_S;
        else if (shifted == 10'd0)
            ret_step = 10'd1;
        else
            ret_step = shifted;
    end

    always_comb begin
        state_nx     = state;
        theta_nx     = theta;
        swing_up_nx  = swing_up;
        frame_cnt_nx = frame_cnt;
        len_nx       = rope_len;
        grabbed_nx   = grabbed;
        returned_nx  = 1'b0;
        case (state)
            SWING: begin
                if (shoot_edge) begin
                    state_nx = EXTEND;
                end else if (startOfFrame) begin
                    if (frame_cnt == DIV_LAST) begin
                        frame_cnt_nx = 8'd0;
                        theta_nx     = theta_step;
                        if (theta_step == TH_MAX)
                            swing_up_nx = 1'b0;
                        else if (theta_step == TH_MIN)
                            swing_up_nx = 1'b1;
                    end else begin
                        frame_cnt_nx = frame_cnt + 8'd1;
                    end
                end
            end
            EXTEND: begin
                if (hook_collision) begin
                    state_nx   = RETRACT;
                    grabbed_nx = 1'b1;
                end else if (border_hit || rope_len == MAX_L) begin
                    state_nx   = RETRACT;
                    grabbed_nx = 1'b0;
                end else if (startOfFrame) begin
                    len_nx = (rope_len >= MAX_L - EXT_S) ? MAX_L : (rope_len + EXT_S);
                end
            end
            RETRACT: begin
                if (startOfFrame) begin
                    if ({1'b0, rope_len} <= ({1'b0, MIN_L} + {1'b0, ret_step})) begin
                        len_nx      = MIN_L;
                        state_nx    = SWING;
                        grabbed_nx  = 1'b0;
                        returned_nx = 1'b1;
                    end else begin
                        len_nx = rope_len - ret_step;
                    end
                end
            end
            default: state_nx = SWING;
        endcase
    end

    hook_tip_calc #(
        .PIVOT_X (PIVOT_X),
        .PIVOT_Y (PIVOT_Y)
    ) u_tip (
        .rope_len  (rope_len),
        .dx        (dx_in),
        .dy        (dy_in),
        .left_side (left_side),
        .tip_x     (tip_x_c),
        .tip_y     (tip_y_c)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state         <= SWING;
            theta         <= 8'd90;
            swing_up      <= 1'b1;
            frame_cnt     <= 8'd0;
            rope_len      <= MIN_L;
            grabbed       <= 1'b0;
            hook_returned <= 1'b0;
            shoot_q       <= 1'b0;
            hookTipX      <= TIP_X_RST;
            hookTipY      <= TIP_Y_RST;
        end else begin
            state         <= state_nx;
            theta         <= theta_nx;
            swing_up      <= swing_up_nx;
            frame_cnt     <= frame_cnt_nx;
            rope_len      <= len_nx;
            grabbed       <= grabbed_nx;
            hook_returned <= returned_nx;
            shoot_q       <= shoot_key;
            hookTipX      <= tip_x_c;
            hookTipY      <= tip_y_c;
        end
    end

endmodule

// File: tb/tb_hook_swing_controller.sv
// Bench for hook_swing_controller: swing table, hand-built shot sequences and a
// randomized run, all checked cycle by cycle against a behavioural model.
module tb_hook_swing_controller;

    localparam int PX   = 320;
    localparam int PY   = 64;
    localparam int MINL = 24;
    localparam int MAXL = 400;
    localparam int TMIN = 10;
    localparam int TMAX = 170;
    localparam int SDIV = 2;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic        shoot_key = 1'b0;
    logic        hook_collision = 1'b0;
    logic        border_hit = 1'b0;
    logic [1:0]  weight = 2'd0;
    logic [9:0]  dx_in = 10'd0;
    logic [9:0]  dy_in = 10'd0;
    logic [6:0]  alpha;
    logic        left_side;
    logic [9:0]  rope_len;
    logic [10:0] hookTipX;
    logic [10:0] hookTipY;
    logic [1:0]  hook_state;
    logic        grabbed;
    logic        hook_returned;

    hook_swing_controller dut (
        .clk            (clk),
        .resetN         (resetN),
        .startOfFrame   (startOfFrame),
        .shoot_key      (shoot_key),
        .hook_collision (hook_collision),
        .border_hit     (border_hit),
        .weight         (weight),
        .dx_in          (dx_in),
        .dy_in          (dy_in),
        .alpha          (alpha),
        .left_side      (left_side),
        .rope_len       (rope_len),
        .hookTipX       (hookTipX),
        .hookTipY       (hookTipY),
        .hook_state     (hook_state),
        .grabbed        (grabbed),
        .hook_returned  (hook_returned)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int dx_tab[0:90];
    int dy_tab[0:90];

    // stimulus levels applied on the next tick
    bit drv_sof, drv_key, drv_coll, drv_border;
    int drv_wt;

    // behavioural model: state 0=swing 1=extend 2=retract
    int m_state, m_theta, m_dir, m_frames, m_rope, m_tx, m_ty;
    bit m_grab, m_ret, m_key_prev;
    int pulses;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_theta = 90; m_dir = 1; m_frames = 0; m_rope = MINL;
        m_grab = 0; m_ret = 0; m_key_prev = 0;
        m_tx = PX; m_ty = PY + (MINL * 1023) / 1024;
    endtask

    function automatic int angle_of(input int th);
        return (th <= 90) ? th : 180 - th;
    endfunction

    task automatic model_clock();
        int a, nx, ny, stepv;
        bit rise;
        a  = angle_of(m_theta);
        nx = (m_theta > 90) ? PX - (m_rope * dx_tab[a]) / 1024 : PX + (m_rope * dx_tab[a]) / 1024;
        ny = PY + (m_rope * dy_tab[a]) / 1024;
        rise = drv_key && !m_key_prev;
        m_key_prev = drv_key;
        m_ret = 0;
        if (m_state == 0) begin
            if (rise) m_state = 1;
            else if (drv_sof) begin
                m_frames = (m_frames + 1) % SDIV;
                if (m_frames == 0) begin
                    m_theta += m_dir;
                    if (m_theta == TMAX || m_theta == TMIN) m_dir = -m_dir;
                end
            end
        end else if (m_state == 1) begin
            if (drv_coll) begin m_state = 2; m_grab = 1; end
            else if (drv_border || m_rope == MAXL) begin m_state = 2; m_grab = 0; end
            else if (drv_sof) m_rope = (m_rope + 4 > MAXL) ? MAXL : m_rope + 4;
        end else begin
            if (drv_sof) begin
                stepv = m_grab ? (((4 >> drv_wt) == 0) ? 1 : (4 >> drv_wt)) : 4;
                if (m_rope - stepv <= MINL) begin
                    m_rope = MINL; m_state = 0; m_grab = 0; m_ret = 1;
                end else m_rope -= stepv;
            end
        end
        m_tx = nx;
        m_ty = ny;
    endtask

    task automatic tick();
        int a;
        @(negedge clk);
        a = (int'(alpha) > 90) ? 90 : int'(alpha);
        dx_in          = 10'(dx_tab[a]);
        dy_in          = 10'(dy_tab[a]);
        startOfFrame   = drv_sof;
        shoot_key      = drv_key;
        hook_collision = drv_coll;
        border_hit     = drv_border;
        weight         = 2'(drv_wt);
        @(posedge clk);
        model_clock();
        #1;
        if (hook_returned) pulses++;
        check("hook_state", int'(hook_state), m_state);
        check("alpha", int'(alpha), angle_of(m_theta));
        check("left_side", int'(left_side), (m_theta > 90) ? 1 : 0);
        check("rope_len", int'(rope_len), m_rope);
        check("hookTipX", int'($signed(hookTipX)), m_tx);
        check("hookTipY", int'($signed(hookTipY)), m_ty);
        check("grabbed", int'(grabbed), int'(m_grab));
        check("hook_returned", int'(hook_returned), int'(m_ret));
    endtask

    task automatic frame();
        drv_sof = 1; tick();
        drv_sof = 0; tick();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, int'(hook_state), 0);
        check({tag, "_alpha"}, int'(alpha), 90);
        check({tag, "_left"}, int'(left_side), 0);
        check({tag, "_rope"}, int'(rope_len), 24);
        check({tag, "_tipx"}, int'($signed(hookTipX)), 320);
        check({tag, "_tipy"}, int'($signed(hookTipY)), 87);
        check({tag, "_grabbed"}, int'(grabbed), 0);
        check({tag, "_returned"}, int'(hook_returned), 0);
    endtask

    task automatic do_reset();
        drv_sof = 0; drv_key = 0; drv_coll = 0; drv_border = 0; drv_wt = 0;
        @(negedge clk);
        shoot_key = 1'b0; startOfFrame = 1'b0; hook_collision = 1'b0; border_hit = 1'b0;
        resetN = 1'b0;
        model_reset();
        @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic press_key();
        drv_key = 0; tick();
        drv_key = 1; tick();
    endtask

    typedef struct {
        int n_frames;
        int exp_alpha;
        int exp_left;
    } swing_vec_t;

    swing_vec_t swing_tbl[7];

    initial begin
        int n;
        for (int a = 0; a <= 90; a++) begin
            int c, s;
            c = $rtoi(1024.0 * $cos(a * 3.14159265358979 / 180.0) + 0.5);
            s = $rtoi(1024.0 * $sin(a * 3.14159265358979 / 180.0) + 0.5);
            dx_tab[a] = (c > 1023) ? 1023 : ((c < 0) ? 0 : c);
            dy_tab[a] = (s > 1023) ? 1023 : ((s < 0) ? 0 : s);
        end
        swing_tbl = '{'{160, 10, 1}, '{2, 11, 1}, '{158, 90, 0}, '{2, 89, 0},
                      '{158, 10, 0}, '{2, 11, 0}, '{160, 89, 1}};
        pulses = 0;

        do_reset();
        #1;
        check_reset_values("reset");

        // swing bounce between the limits
        for (int i = 0; i < 7; i++) begin
            frames(swing_tbl[i].n_frames);
            check($sformatf("swing%0d_alpha", i), int'(alpha), swing_tbl[i].exp_alpha);
            check($sformatf("swing%0d_left", i), int'(left_side), swing_tbl[i].exp_left);
        end

        // tip math at theta 135, rope 100, then an empty shot with the key held
        do_reset();
        frames(90);
        check("tip_alpha45", int'(alpha), 45);
        press_key();
        check("shoot_extend", int'(hook_state), 1);
        frames(19);
        check("tip_rope100", int'(rope_len), 100);
        check("tip_x250", int'($signed(hookTipX)), 250);
        check("tip_y134", int'($signed(hookTipY)), 134);
        n = 0;
        while (rope_len != 10'd400 && n < 120) begin frame(); n++; end
        check("extend_frames", n, 75);
        check("empty_retract", int'(hook_state), 2);
        check("empty_grabbed", int'(grabbed), 0);
        pulses = 0; n = 0;
        while (hook_state != 2'd0 && n < 200) begin frame(); n++; end
        check("empty_return_frames", n, 94);
        check("empty_pulses", pulses, 1);
        check("empty_rope_rest", int'(rope_len), 24);
        frames(10);
        check("held_key_no_relaunch", int'(hook_state), 0);

        // heavy grab: collision and border together, weight 2
        press_key();
        drv_key = 0;
        frames(44);
        check("grab_rope200", int'(rope_len), 200);
        drv_coll = 1; drv_border = 1; tick();
        drv_coll = 0; drv_border = 0;
        check("grab_retract", int'(hook_state), 2);
        check("grab_grabbed", int'(grabbed), 1);
        drv_wt = 2;
        pulses = 0; n = 0;
        while (hook_state != 2'd0 && n < 300) begin frame(); n++; end
        check("grab_return_frames", n, 176);
        check("grab_cleared", int'(grabbed), 0);
        check("grab_pulses", pulses, 1);
        drv_wt = 0;

        // asynchronous reset in the middle of an extension
        press_key();
        drv_key = 0;
        frames(24);
        check("midext_rope120", int'(rope_len), 120);
        #2;
        resetN = 1'b0;
        #1;
        check_reset_values("async");
        model_reset();
        drv_sof = 0; drv_key = 0; drv_coll = 0; drv_border = 0; drv_wt = 0;
        @(negedge clk);
        shoot_key = 1'b0; startOfFrame = 1'b0;
        resetN = 1'b1;

        // randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            drv_sof    = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) drv_key = ~drv_key;
            drv_coll   = ($urandom_range(0, 59) == 0);
            drv_border = ($urandom_range(0, 79) == 0);
            drv_wt     = int'($urandom_range(0, 3));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
